fetch_unit: RTL and testbench

Instruction-fetch stage directly downstream of the program counter. Takes the current PC and issues one request at a time to instruction memory over a req/addr_ok/data_ok handshake. Delivers instruction, PC and an address-error flag to decode through a one-entry valid/ready output register. Pulses `pc_advance` so the PC moves on only after a fetch completes. Drops in-flight results on a pipeline redirect (exception, eret, taken branch or jump).

---
 rtl/fetch_unit.sv | 70 +++++++
 tb/tb_fetch_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect discard and one-entry output register
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        pc_advance,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_adel
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_e;
  state_e      state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] addr_q, addr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_adel_q, id_adel_d;
  logic        slot_free, issue, adel_load, data_load;
  always_comb begin
    slot_free  = !id_valid_q || id_ready;
    issue      = state_q == IDLE && !flush && slot_free && pc[1:0] == 2'b00;
    adel_load  = state_q == IDLE && !flush && slot_free && pc[1:0] != 2'b00;
    data_load  = state_q == WAIT && inst_data_ok && !flush;
    pc_advance = !rst && (adel_load || data_load);
    state_d    = state_q == IDLE ? (issue ? REQ : IDLE) :
                 state_q == REQ  ? (inst_addr_ok ? ((flush || kill_q) ? DISCARD : WAIT) : REQ) :
                 state_q == WAIT ? (inst_data_ok ? IDLE : flush ? DISCARD : WAIT) :
                                   (inst_data_ok ? IDLE : DISCARD);
    kill_d     = state_q == REQ && !inst_addr_ok && (flush || kill_q);
    addr_d     = issue ? pc : addr_q;
    id_valid_d = flush ? 1'b0 : (adel_load || data_load) ? 1'b1 : id_ready ? 1'b0 : id_valid_q;
    id_adel_d  = flush ? 1'b0 : adel_load ? 1'b1 : data_load ? 1'b0 : id_adel_q;
    id_inst_d  = adel_load ? 32'h0 : data_load ? inst_rdata : id_inst_q;
    id_pc_d    = (issue || adel_load) ? pc : id_pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      addr_q     <= 32'h0;
      id_valid_q <= 1'b0;
      id_inst_q  <= 32'h0;
      id_pc_q    <= 32'h0;
      id_adel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      addr_q     <= addr_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_adel_q  <= id_adel_d;
    end
  end
  assign inst_req  = state_q == REQ;
  assign inst_addr = addr_q;
  assign id_valid  = id_valid_q;
  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;
  assign id_adel   = id_adel_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario checks of fetch_unit handshakes, backpressure, redirects and reset
module tb_fetch_unit;
  logic        clk, rst, flush, pc_advance, inst_req, inst_addr_ok, inst_data_ok;
  logic        id_valid, id_ready, id_adel;
  logic [31:0] pc, inst_addr, inst_rdata, id_inst, id_pc;
  int tests = 0;
  int fails = 0;
  fetch_unit dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .pc_advance(pc_advance),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .id_adel(id_adel)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; pc = 32'hBFC0_0380; id_ready = 1'b1; flush = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    cyc(); cyc(); #1;
    tests++; if (pc_advance !== 1'b0) begin fails++; $display("FAIL reset_pc_advance got %b want 0", pc_advance); end
    tests++; if (inst_req !== 1'b0) begin fails++; $display("FAIL reset_inst_req got %b want 0", inst_req); end
    tests++; if ({inst_addr, id_inst, id_pc} !== 96'h0) begin fails++; $display("FAIL reset_regs got %h %h %h want 0", inst_addr, id_inst, id_pc); end
    tests++; if ({id_valid, id_adel} !== 2'b00) begin fails++; $display("FAIL reset_valid_adel got %b%b want 00", id_valid, id_adel); end
    rst = 1'b0;
  endtask
  task automatic test_zero_wait();
    do_reset();
    pc = 32'hBFC0_0380; id_ready = 1'b1; #1;
    tests++; if (pc_advance !== 1'b0) begin fails++; $display("FAIL zw_adv_n got %b want 0", pc_advance); end
    cyc(); inst_addr_ok = 1'b1; #1;
    tests++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0380) begin fails++; $display("FAIL zw_req_n1 got %b %h want 1 bfc00380", inst_req, inst_addr); end
    tests++; if (pc_advance !== 1'b0) begin fails++; $display("FAIL zw_adv_n1 got %b want 0", pc_advance); end
    cyc(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001; #1;
    tests++; if (pc_advance !== 1'b1 || inst_req !== 1'b0) begin fails++; $display("FAIL zw_adv_n2 got %b req %b want 1 0", pc_advance, inst_req); end
    cyc(); inst_data_ok = 1'b0; pc = 32'hBFC0_0384; #1;
    tests++; if (id_valid !== 1'b1 || id_inst !== 32'h2408_0001 || id_pc !== 32'hBFC0_0380 || id_adel !== 1'b0)
      begin fails++; $display("FAIL zw_out_n3 got v%b %h %h a%b want v1 24080001 bfc00380 a0", id_valid, id_inst, id_pc, id_adel); end
    tests++; if (pc_advance !== 1'b0) begin fails++; $display("FAIL zw_adv_n3 got %b want 0", pc_advance); end
    cyc();
    tests++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0384 || id_valid !== 1'b0) begin fails++; $display("FAIL zw_req_n4 got %b %h v%b want 1 bfc00384 v0", inst_req, inst_addr, id_valid); end
  endtask
  task automatic test_backpressure();
    do_reset();
    pc = 32'h0000_1000; id_ready = 1'b1;
    cyc(); inst_addr_ok = 1'b1;
    cyc(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hAAAA_5555;
    cyc(); inst_data_ok = 1'b0; pc = 32'h0000_1004; id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (inst_req !== 1'b0 || id_valid !== 1'b1 || id_inst !== 32'hAAAA_5555 || id_pc !== 32'h0000_1000 || pc_advance !== 1'b0)
        begin fails++; $display("FAIL bp_hold%0d got req%b v%b %h %h adv%b want req0 v1 aaaa5555 00001000 adv0", i, inst_req, id_valid, id_inst, id_pc, pc_advance); end
      cyc();
    end
    id_ready = 1'b1;
    cyc();
    tests++; if (inst_req !== 1'b1 || inst_addr !== 32'h0000_1004 || id_valid !== 1'b0) begin fails++; $display("FAIL bp_release got %b %h v%b want 1 00001004 v0", inst_req, inst_addr, id_valid); end
  endtask
  task automatic test_flush_wait();
    do_reset();
    pc = 32'h0000_2000; id_ready = 1'b1;
    cyc(); inst_addr_ok = 1'b1;
    cyc(); inst_addr_ok = 1'b0; flush = 1'b1; #1;
    tests++; if (pc_advance !== 1'b0) begin fails++; $display("FAIL fw_adv_flush got %b want 0", pc_advance); end
    cyc(); flush = 1'b0; pc = 32'h8000_0180; #1;
    tests++; if (pc_advance !== 1'b0 || inst_req !== 1'b0 || id_valid !== 1'b0) begin fails++; $display("FAIL fw_discard got adv%b req%b v%b want 000", pc_advance, inst_req, id_valid); end
    cyc(); inst_data_ok = 1'b1; inst_rdata = 32'h1234_5678; #1;
    tests++; if (pc_advance !== 1'b0) begin fails++; $display("FAIL fw_adv_data got %b want 0", pc_advance); end
    cyc(); inst_data_ok = 1'b0;
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL fw_valid got %b want 0", id_valid); end
    cyc();
    tests++; if (inst_req !== 1'b1 || inst_addr !== 32'h8000_0180) begin fails++; $display("FAIL fw_redirect got %b %h want 1 80000180", inst_req, inst_addr); end
  endtask
  task automatic test_flush_req();
    do_reset();
    pc = 32'h0000_3000; id_ready = 1'b1;
    cyc(); flush = 1'b1;
    tests++; if (inst_req !== 1'b1 || inst_addr !== 32'h0000_3000) begin fails++; $display("FAIL fr_req0 got %b %h want 1 00003000", inst_req, inst_addr); end
    cyc(); flush = 1'b0; pc = 32'h8000_0180;
    for (int i = 0; i < 2; i++) begin
      tests++; if (inst_req !== 1'b1 || inst_addr !== 32'h0000_3000) begin fails++; $display("FAIL fr_hold%0d got %b %h want 1 00003000", i, inst_req, inst_addr); end
      cyc();
    end
    inst_addr_ok = 1'b1;
    tests++; if (inst_req !== 1'b1 || inst_addr !== 32'h0000_3000) begin fails++; $display("FAIL fr_accept got %b %h want 1 00003000", inst_req, inst_addr); end
    cyc(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF; #1;
    tests++; if (inst_req !== 1'b0 || pc_advance !== 1'b0) begin fails++; $display("FAIL fr_discard got req%b adv%b want 00", inst_req, pc_advance); end
    cyc(); inst_data_ok = 1'b0;
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL fr_valid got %b want 0", id_valid); end
    cyc();
    tests++; if (inst_req !== 1'b1 || inst_addr !== 32'h8000_0180) begin fails++; $display("FAIL fr_redirect got %b %h want 1 80000180", inst_req, inst_addr); end
  endtask
  task automatic test_misaligned();
    do_reset();
    pc = 32'h0040_0002; id_ready = 1'b0; #1;
    tests++; if (inst_req !== 1'b0 || pc_advance !== 1'b1) begin fails++; $display("FAIL ma_same got req%b adv%b want 0 1", inst_req, pc_advance); end
    cyc(); pc = 32'h0040_0006; #1;
    tests++; if (id_valid !== 1'b1 || id_adel !== 1'b1 || id_inst !== 32'h0 || id_pc !== 32'h0040_0002)
      begin fails++; $display("FAIL ma_out got v%b a%b %h %h want v1 a1 0 00400002", id_valid, id_adel, id_inst, id_pc); end
    tests++; if (inst_req !== 1'b0 || pc_advance !== 1'b0) begin fails++; $display("FAIL ma_blocked got req%b adv%b want 00", inst_req, pc_advance); end
    flush = 1'b1;
    cyc(); flush = 1'b0;
    tests++; if (id_valid !== 1'b0 || id_adel !== 1'b0) begin fails++; $display("FAIL ma_flush got v%b a%b want 00", id_valid, id_adel); end
  endtask
  task automatic test_reset_in_wait();
    do_reset();
    pc = 32'h0000_4000; id_ready = 1'b1;
    cyc(); inst_addr_ok = 1'b1;
    cyc(); inst_addr_ok = 1'b0; rst = 1'b1; #1;
    tests++; if (pc_advance !== 1'b0) begin fails++; $display("FAIL rw_adv_rst got %b want 0", pc_advance); end
    cyc(); rst = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hBADB_AD00; #1;
    tests++; if (inst_req !== 1'b0 || inst_addr !== 32'h0 || id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0 || id_adel !== 1'b0)
      begin fails++; $display("FAIL rw_regs got req%b %h v%b %h %h a%b want all 0", inst_req, inst_addr, id_valid, id_inst, id_pc, id_adel); end
    tests++; if (pc_advance !== 1'b0) begin fails++; $display("FAIL rw_stray got %b want 0", pc_advance); end
    cyc(); inst_data_ok = 1'b0;
    tests++; if (inst_req !== 1'b1 || inst_addr !== 32'h0000_4000 || id_valid !== 1'b0) begin fails++; $display("FAIL rw_req got %b %h v%b want 1 00004000 v0", inst_req, inst_addr, id_valid); end
    inst_addr_ok = 1'b1;
    cyc(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_2222; #1;
    tests++; if (pc_advance !== 1'b1) begin fails++; $display("FAIL rw_adv got %b want 1", pc_advance); end
    cyc(); inst_data_ok = 1'b0;
    tests++; if (id_valid !== 1'b1 || id_inst !== 32'h1111_2222 || id_pc !== 32'h0000_4000) begin fails++; $display("FAIL rw_out got v%b %h %h want v1 11112222 00004000", id_valid, id_inst, id_pc); end
  endtask
  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_flush_wait();
    test_flush_req();
    test_misaligned();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
